// File: rtl/dlx_pkg.sv
// Shared DLX datapath definitions: widths and the operand-latch state encoding.
package dlx_pkg;

  localparam int DLX_W     = 32;
  localparam int DLX_IMM_W = 16;

  // Bit 0 means "A held" and bit 1 means "B held", so FULL is both bits set.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_HAVE_A = 2'b01,
    ST_HAVE_B = 2'b10,
    ST_FULL   = 2'b11
  } opl_state_t;

endpackage

// File: rtl/imm_extend.sv
// Immediate extender: widens an I-type immediate to datapath width.
// It is shared with the ALU immediate path.
module imm_extend
  import dlx_pkg::*;
#(
  parameter int W     = DLX_W,
  parameter int IMM_W = DLX_IMM_W
) (
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_sext,
  output logic [W-1:0]     o_ext
);

  logic w_fill;

  // The upper bits copy the immediate's MSB for sign-extend, or are zero for zero-extend.
  assign w_fill = i_sext & i_imm[IMM_W-1];
  assign o_ext  = {{(W-IMM_W){w_fill}}, i_imm};

endmodule

// File: rtl/dlx_operand_latch.sv
// Operand capture stage in front of the bitwise logic units.
// It collects A and B from the shared bus, or takes B from the immediate.
// It then presents the pair under a valid/ready handshake.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_EMPTY  | no operand held for the next pair
//   ST_HAVE_A | A captured, waiting for B
//   ST_HAVE_B | B captured, waiting for A
//   ST_FULL   | pair complete and stable, o_out_valid high
module dlx_operand_latch
  import dlx_pkg::*;
#(
  parameter int W     = DLX_W,
  parameter int IMM_W = DLX_IMM_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W-1:0]     i_bus_in,
  input  logic             i_ld_a,
  input  logic             i_ld_b,
  input  logic             i_ld_imm,
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_imm_sext,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_b,
  output logic             o_busy,
  output logic             o_overrun
);

  opl_state_t r_state;
  opl_state_t w_state_nxt;
  opl_state_t w_base;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_overrun;
  logic [W-1:0] w_imm_ext;
  logic [W-1:0] w_b_src;
  logic         w_ld_b;
  logic         w_xfer;
  logic         w_accept;
  logic         w_en_a;
  logic         w_en_b;
  logic         w_overrun_set;

  imm_extend #(
    .W     (W),
    .IMM_W (IMM_W)
  ) u_imm_extend (
    .i_imm  (i_imm),
    .i_sext (i_imm_sext),
    .o_ext  (w_imm_ext)
  );

  // B source: when both B loads are asserted, the immediate takes precedence.
  assign w_ld_b  = i_ld_b | i_ld_imm;
  assign w_b_src = i_ld_imm ? w_imm_ext : i_bus_in;
  assign w_xfer  = (r_state == ST_FULL) & i_out_ready;

  // Next state and load enables.
  // A transfer cycle is evaluated as if starting from EMPTY, so new loads refill with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_base      = w_xfer ? ST_EMPTY : r_state;
    case (w_base)
      ST_EMPTY: begin
        if (i_ld_a && w_ld_b) w_state_nxt = ST_FULL;
        else if (i_ld_a)      w_state_nxt = ST_HAVE_A;
        else if (w_ld_b)      w_state_nxt = ST_HAVE_B;
        else                  w_state_nxt = ST_EMPTY;
      end
      ST_HAVE_A: w_state_nxt = w_ld_b ? ST_FULL : ST_HAVE_A;
      ST_HAVE_B: w_state_nxt = i_ld_a ? ST_FULL : ST_HAVE_B;
      ST_FULL:   w_state_nxt = ST_FULL;
      default:   w_state_nxt = ST_EMPTY;
    endcase
    w_accept      = (w_base != ST_FULL);
    w_en_a        = i_ld_a & w_accept;
    w_en_b        = w_ld_b & w_accept;
    w_overrun_set = ~w_accept & (i_ld_a | w_ld_b);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Operand registers. They are not cleared on transfer; stale values are masked by o_out_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_en_a) r_a <= i_bus_in;
      if (w_en_b) r_b <= w_b_src;
    end
  end

  // Sticky overrun flag: it is set when a load hits a full pair that is not leaving this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)              r_overrun <= 1'b0;
    else if (w_overrun_set) r_overrun <= 1'b1;
  end

  assign o_out_valid = (r_state == ST_FULL);
  assign o_busy      = (r_state != ST_EMPTY);
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_dlx_operand_latch.sv
// Testbench for dlx_operand_latch: directed scenarios followed by a random phase,
// all checked against a flag-based operand model.
module tb_dlx_operand_latch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_bus_in = '0;
  logic        i_ld_a = 1'b0, i_ld_b = 1'b0, i_ld_imm = 1'b0;
  logic [15:0] i_imm = '0;
  logic        i_imm_sext = 1'b0;
  logic        i_out_ready = 1'b0;
  logic        o_out_valid, o_busy, o_overrun;
  logic [31:0] o_a, o_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_have_a, m_have_b, m_ovr;
  logic [31:0] m_a, m_b;
  int          m_nxfer;

  dlx_operand_latch dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bus_in    (i_bus_in),
    .i_ld_a      (i_ld_a),
    .i_ld_b      (i_ld_b),
    .i_ld_imm    (i_ld_imm),
    .i_imm       (i_imm),
    .i_imm_sext  (i_imm_sext),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext16(input logic [15:0] v, input bit s);
    logic [31:0] e;
    e = {16'h0000, v};
    if (s && v >= 16'h8000) e = e + 32'hFFFF_0000;
    return e;
  endfunction

  // Drives one cycle of inputs, advances the model across the edge, and checks outputs #1 after the edge.
  task automatic cyc(input bit rst, input bit lda, input bit ldb, input bit ldimm,
                     input logic [31:0] bus, input logic [15:0] imm, input bit sext,
                     input bit rdy);
    bit          full, xfer, bload;
    logic [31:0] bval;
    i_rst = rst; i_ld_a = lda; i_ld_b = ldb; i_ld_imm = ldimm;
    i_bus_in = bus; i_imm = imm; i_imm_sext = sext; i_out_ready = rdy;
    full = m_have_a && m_have_b;
    xfer = full && rdy && !rst;
    if (xfer) begin
      chk("xfer_a", o_a, m_a);
      chk("xfer_b", o_b, m_b);
    end
    @(posedge i_clk);
    if (rst) begin
      m_have_a = 0; m_have_b = 0; m_ovr = 0; m_a = '0; m_b = '0;
    end else begin
      if (xfer) begin
        m_have_a = 0; m_have_b = 0; m_nxfer++;
      end
      bload = ldb || ldimm;
      bval  = ldimm ? ext16(imm, sext) : bus;
      if (m_have_a && m_have_b) begin
        if (lda || bload) m_ovr = 1;
      end else begin
        if (lda)   begin m_a = bus;  m_have_a = 1; end
        if (bload) begin m_b = bval; m_have_b = 1; end
      end
    end
    #1;
    chk("valid",   {31'b0, o_out_valid}, {31'b0, m_have_a && m_have_b});
    chk("busy",    {31'b0, o_busy},      {31'b0, m_have_a || m_have_b});
    chk("overrun", {31'b0, o_overrun},   {31'b0, m_ovr});
    chk("a", o_a, m_a);
    chk("b", o_b, m_b);
  endtask

  initial begin
    int x0;
    logic [31:0] held_a;

    m_have_a = 0; m_have_b = 0; m_ovr = 0; m_a = '0; m_b = '0; m_nxfer = 0;

    // Reset
    cyc(1, 0, 0, 0, 32'h0, 16'h0, 0, 0);
    cyc(1, 1, 1, 0, 32'h1234_5678, 16'h0, 0, 1);
    chk("rst_a", o_a, 32'h0);
    chk("rst_valid", {31'b0, o_out_valid}, 32'h0);

    // Two-cycle collection followed by a hold with ready low
    cyc(0, 1, 0, 0, 32'hF0F0_1234, 16'h0, 0, 0);
    chk("have_a_valid", {31'b0, o_out_valid}, 32'h0);
    cyc(0, 0, 1, 0, 32'h0FF0_FFFF, 16'h0, 0, 0);
    chk("pair_valid", {31'b0, o_out_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, $urandom, 16'h0, 0, 0);
      chk("and_result", o_a & o_b, 32'h00F0_1234);
    end
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);

    // Immediate sign/zero extension; LD_B together with LD_IMM lets the immediate win
    cyc(0, 1, 0, 0, 32'hFFFF_FFFF, 16'h0, 0, 0);
    cyc(0, 0, 1, 1, 32'h1111_1111, 16'h8001, 1, 0);
    chk("imm_sext", o_b, 32'hFFFF_8001);
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);
    cyc(0, 1, 0, 0, 32'hFFFF_FFFF, 16'h0, 0, 0);
    cyc(0, 0, 0, 1, 32'h2222_2222, 16'h8001, 0, 0);
    chk("imm_zext", o_b, 32'h0000_8001);

    // A load while FULL is ignored and sets the sticky overrun flag
    held_a = o_a;
    cyc(0, 1, 0, 0, 32'hDEAD_BEEF, 16'h0, 0, 0);
    chk("ovr_a_hold", o_a, held_a);
    chk("ovr_set", {31'b0, o_overrun}, 32'h1);
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);
    cyc(0, 1, 1, 0, 32'h7777_0000, 16'h0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);
    chk("ovr_sticky", {31'b0, o_overrun}, 32'h1);
    cyc(1, 0, 0, 0, 32'h0, 16'h0, 0, 0);
    chk("ovr_rst", {31'b0, o_overrun}, 32'h0);

    // Transfer with a same-cycle refill
    cyc(0, 1, 1, 0, 32'h1357_9BDF, 16'h0, 0, 0);
    cyc(0, 1, 1, 0, 32'h5555_AAAA, 16'h0, 0, 1);
    chk("refill_valid", {31'b0, o_out_valid}, 32'h1);
    chk("refill_a", o_a, 32'h5555_AAAA);
    chk("refill_b", o_b, 32'h5555_AAAA);
    chk("refill_ovr", {31'b0, o_overrun}, 32'h0);

    // Sustained stream: one transfer per cycle
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);
    cyc(0, 1, 1, 0, $urandom, 16'h0, 0, 1);
    x0 = m_nxfer;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, $urandom, 16'h0, 0, 1);
    end
    chk("stream_count", m_nxfer - x0, 32'd8);
    chk("stream_ovr", {31'b0, o_overrun}, 32'h0);

    // Reset in HAVE_A coinciding with LD_B
    cyc(0, 0, 0, 0, 32'h0, 16'h0, 0, 1);
    cyc(0, 1, 0, 0, 32'hABCD_0001, 16'h0, 0, 0);
    cyc(1, 0, 1, 0, 32'h9999_9999, 16'h0, 0, 0);
    chk("mid_rst_a", o_a, 32'h0);
    chk("mid_rst_b", o_b, 32'h0);
    chk("mid_rst_busy", {31'b0, o_busy}, 32'h0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom_range(0, 1),
          $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlx_operand_latch.md
# dlx_operand_latch

Operand capture stage directly upstream of the 32-bit bitwise logic units (AND/OR/XOR) in the Extended DLX datapath. It collects the A and B operands from the single shared 32-bit datapath bus over separate cycles, or takes B from a sign- or zero-extended 16-bit immediate. It then presents a stable operand pair to the combinational logic unit under a valid/ready handshake. It also flags control-sequencing errors with a sticky overrun bit.

## Interface
- `W`, 32, operand/bus width
- `IMM_W`, 16, immediate width (I-type field)
- `CLK` input 1 system clock, rising-edge
- `RST` input 1 synchronous, active-high reset
- `BUS_IN` input W shared datapath bus value
- `LD_A` input 1 capture `BUS_IN` into operand A this cycle
- `LD_B` input 1 capture `BUS_IN` into operand B this cycle
- `LD_IMM` input 1 capture extended `IMM` into operand B this cycle
- `IMM` input IMM_W immediate field
- `IMM_SEXT` input 1 1 = sign-extend `IMM`, 0 = zero-extend
- `OUT_READY` input 1 downstream logic/result stage accepts the pair
- `OUT_VALID` output 1 A and B both loaded, pair stable
- `A` output W operand A to logic unit
- `B` output W operand B to logic unit
- `BUSY` output 1 at least one operand loaded, pair not yet consumed
- `OVERRUN` output 1 sticky; a load arrived while FULL without a transfer

## Operation
- FSM states: EMPTY, HAVE_A, HAVE_B, FULL. `OUT_VALID` = (state == FULL). `BUSY` = (state != EMPTY).
- B-load = `LD_B | LD_IMM`. When both are asserted, `LD_IMM` wins and B = ext(`IMM`).
- Extension: sign-extend copies `IMM[IMM_W-1]` into bits W-1..IMM_W; zero-extend fills those bits with 0.
- Transfer occurs on a cycle where `OUT_VALID & OUT_READY`. `A`/`B` hold their values until the edge.
- Transitions, evaluated per rising edge with no transfer:
  - EMPTY: A-load only -> HAVE_A; B-load only -> HAVE_B; both -> FULL.
  - HAVE_A: B-load -> FULL; A-load reloads A and stays in HAVE_A.
  - HAVE_B: the mirror of HAVE_A.
  - FULL: stays FULL; any load is ignored (registers unchanged) and sets `OVERRUN`.
- Transfer cycle: the state is computed as from EMPTY using that cycle's loads. A simultaneous load refills the next pair with no bubble, and `OVERRUN` is not set.
- `LD_A & LD_B` in the same cycle loads the same `BUS_IN` into both registers. This is legal (e.g. Rx AND Rx).
- `OVERRUN` clears only on `RST`.
- Operand registers are not cleared on transfer. Stale values remain visible while `OUT_VALID`=0 and must not be consumed.

## Timing
- Reset (`RST`=1 at an edge): state EMPTY, `A`=0, `B`=0, `OUT_VALID`=0, `BUSY`=0, `OVERRUN`=0.
- Reset has priority over all loads and transfers in the same cycle, including reset mid-collection (HAVE_A/HAVE_B).
- All outputs are registered or decoded directly from registered state. There is no combinational path from `OUT_READY` or the load inputs to any output.
- Latency: an operand load at edge n makes the value visible on `A`/`B` after edge n. Second operand at edge n -> `OUT_VALID`=1 after edge n.
- Throughput: with `LD_A`, `LD_B` and `OUT_READY` all high every cycle, one pair per cycle is sustained.
- `OUT_VALID` stays high until a transfer. `A`/`B` must not change while `OUT_VALID`=1 and `OUT_READY`=0.

## Structure
- Shared package `dlx_pkg`: state encoding (EMPTY=2'b00, HAVE_A=2'b01, HAVE_B=2'b10, FULL=2'b11), `DLX_W`=32, `DLX_IMM_W`=16.
- One natural sub-module: `imm_extend` (combinational, `IMM`/`IMM_SEXT` -> W-bit value), shareable with the ALU immediate path.
- Everything else stays flat: two W-bit registers, a 2-bit state register, and a sticky flop.

## Test plan
- Reset then `LD_A` with `BUS_IN`=32'hF0F0_1234, then `LD_B` with 32'h0FF0_FFFF, `OUT_READY`=0 -> `OUT_VALID`=1 after the second edge, `A`/`B` hold those values for 5 cycles; a downstream AND yields 32'h00F0_1234.
- `LD_A` 32'hFFFF_FFFF, then `LD_IMM` with `IMM`=16'h8001: `IMM_SEXT`=1 -> B=32'hFFFF_8001; repeated with `IMM_SEXT`=0 -> B=32'h0000_8001.
- FULL with `OUT_READY`=0, pulse `LD_A` with 32'hDEAD_BEEF -> A unchanged, `OVERRUN`=1 and stays 1 after later transfers until `RST`.
- FULL with `OUT_READY`=1 and the same cycle `LD_A`+`LD_B` with `BUS_IN`=32'h5555_AAAA -> transfer of the old pair, new pair A=B=32'h5555_AAAA, `OUT_VALID` stays 1, `OVERRUN`=0.
- Sustained stream: 8 pairs with all loads and `OUT_READY` high every cycle -> 8 transfers in 8 consecutive cycles, each with the correct values.
- `RST` asserted in HAVE_A coincident with `LD_B` -> EMPTY, `A`=`B`=0, `OUT_VALID`=0, `BUSY`=0.
